uart_axis_rx: RTL
=================

Name: uart_axis_rx

Overview:
Standalone UART receiver that deserialises an asynchronous serial line into an AXI4-Stream master output. It pairs with the team's AXI-Stream-fed UART transmitter across a link or loopback, and carries the same frame parameters (data width, parity, stop bits). It adds start-bit glitch rejection, per-frame error pulses, and overrun detection when the downstream stalls.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD_RATE, 115200, line bit rate; BAUD_DIV = CLK_FREQ/BAUD_RATE (integer division, 434 at defaults), HALF_DIV = BAUD_DIV/2 (217)
DATA_WIDTH, 8, data bits per frame, LSB first, legal 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BIT, 1, number of stop bits, 1 or 2

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
rx_wire  input  1  serial line, idle high, asynchronous to clk
m_axis_tdata  output  DATA_WIDTH  received word
m_axis_tvalid  output  1  word available
m_axis_tready  input  1  downstream accepts word
frame_error  output  1  one-cycle pulse: a stop bit was sampled low
parity_error  output  1  one-cycle pulse: parity mismatch
overrun_error  output  1  one-cycle pulse: word dropped because the holding register was full

Behaviour:
- Reset values: m_axis_tdata = 0, m_axis_tvalid = 0, all error pulses = 0, FSM = IDLE, counters = 0, synchroniser flops = 1.
- rx_wire passes through a 2-FF synchroniser to give rx_s. Only rx_s and its 1-cycle-delayed copy are used.
- Baud counter counts 0..BAUD_DIV-1 and is cleared on every state entry.
- FSM states: IDLE, START, DATA, PAR, STOP, BREAK.
- IDLE: a falling edge on rx_s (previous 1, current 0) moves to START.
- START: sample rx_s when the counter reaches HALF_DIV-1.
  - Sample 0 -> DATA.
  - Sample 1 -> glitch; return to IDLE with no output and no error.
- DATA: sample at counter = BAUD_DIV-1, i.e. mid-bit.
  - Shift into the data register LSB first; bit_idx runs 0..DATA_WIDTH-1.
  - After the last bit: go to PAR if PARITY != 0, else STOP.
- PAR: sample one bit at BAUD_DIV-1.
  - Expected bit: odd parity = ~^data, even parity = ^data.
  - Mismatch latches an internal par_bad flag.
- STOP: sample STOP_BIT bits at BAUD_DIV-1 each.
  - Any 0 sample ends the frame immediately and sets frame_bad.
  - The FSM leaves STOP at the mid-point of the last stop bit, giving half a bit of resync margin.
- Frame completion (the cycle after the last stop sample, or after the failing stop sample):
  - frame_bad: pulse frame_error, discard the word, go to BREAK. Do not also pulse parity_error.
  - Otherwise pulse parity_error if par_bad is set. The word is still delivered (parity is advisory). Go to IDLE.
- BREAK: wait until rx_s = 1, then go to IDLE. A line held low never generates repeated frames.
- Output holding register follows AXI-Stream rules:
  - tdata and tvalid stay stable until tvalid && tready.
  - tvalid falls the cycle after acceptance unless a new word loads in that same cycle.
- Delivering a word:
  - If tvalid = 0, or tvalid && tready in the completion cycle: load tdata, set tvalid = 1 (next cycle). No overrun.
  - If tvalid = 1 and tready = 0: drop the new word, pulse overrun_error, leave tdata unchanged.
- Latency: tvalid rises 3 + HALF_DIV + (DATA_WIDTH + P + STOP_BIT - 1) × BAUD_DIV + BAUD_DIV (±2 cycles) after the rx_wire falling edge, where P = (PARITY != 0).
- Reset asserted mid-frame: immediate return to reset values; a partial word is never output.

Test Plan:
- 8N1 at defaults, send 0xA5, tready = 1 -> exactly one tvalid pulse with tdata = 0xA5, no error pulses, inside the latency window above.
- PARITY = 2, send 0x3C with the parity bit forced to 1 -> tdata = 0x3C delivered, parity_error pulses once coincident with frame completion. The correct parity bit gives no error.
- Send 0x55 with the stop bit driven 0 and the line held low for 3 bit times -> frame_error pulses exactly once, no tvalid, FSM stays in BREAK until rx high, then a following 0x66 is received correctly.
- Low glitch of 100 cycles (< HALF_DIV) on an idle line -> no tvalid, no error pulses, FSM back in IDLE.
- tready = 0, send 0x11 then 0x22 -> tdata holds 0x11, overrun_error pulses once at the second completion. Raise tready -> one transfer of 0x11, then tvalid = 0.
- STOP_BIT = 2, PARITY = 1, back-to-back stream 0x00..0xFF with tready = 1 -> 256 words in order, zero errors. Assert rst mid-frame on word 0x80 -> outputs at reset values, next full frame received cleanly.

Source files
------------

// File: rtl/uart_axis_rx.sv
// UART receiver: 2-FF synchronised serial input, mid-bit sampling FSM and an
// AXI4-Stream holding register with frame, parity and overrun error pulses.
module uart_axis_rx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_WIDTH = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BIT   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_wire,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  frame_error,
  output logic                  parity_error,
  output logic                  overrun_error
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int HALF_DIV = BAUD_DIV / 2;
  localparam int CW       = $clog2(BAUD_DIV + 1);
  localparam int IW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CW-1:0] LAST_CNT  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_CNT  = CW'(HALF_DIV - 1);
  localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_WIDTH - 1);
  localparam logic          LAST_STOP = (STOP_BIT == 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BREAK} state_t;

  state_t                state_q, state_d;
  logic                  sync1_q, rxS_q, rxPrev_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         bitIdx_q, bitIdx_d;
  logic                  stopIdx_q, stopIdx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  parBad_q, parBad_d;
  logic                  frameBad_q, frameBad_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] tdata_q;
  logic                  tvalid_q, frameErr_q, parErr_q, overrun_q;
  logic                  parExp;

  assign parExp = (PARITY == 1) ? ~^shift_q : ^shift_q;

  // Flops reset high so the idle line never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b1;
      rxS_q    <= 1'b1;
      rxPrev_q <= 1'b1;
    end else begin
      sync1_q  <= rx_wire;
      rxS_q    <= sync1_q;
      rxPrev_q <= rxS_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bitIdx_q   <= '0;
      stopIdx_q  <= 1'b0;
      shift_q    <= '0;
      parBad_q   <= 1'b0;
      frameBad_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bitIdx_q   <= bitIdx_d;
      stopIdx_q  <= stopIdx_d;
      shift_q    <= shift_d;
      parBad_q   <= parBad_d;
      frameBad_q <= frameBad_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = (cnt_q == LAST_CNT) ? '0 : cnt_q + CW'(1);
    bitIdx_d   = bitIdx_q;
    stopIdx_d  = stopIdx_q;
    shift_d    = shift_q;
    parBad_d   = parBad_q;
    frameBad_d = frameBad_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d      = '0;
        bitIdx_d   = '0;
        stopIdx_d  = 1'b0;
        parBad_d   = 1'b0;
        frameBad_d = 1'b0;
        if (rxPrev_q && !rxS_q) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_CNT) state_d = rxS_q ? IDLE : DATA;
      end
      DATA: begin
        if (cnt_q == LAST_CNT) begin
          shift_d = {rxS_q, shift_q[DATA_WIDTH-1:1]};
          if (bitIdx_q == LAST_BIT) begin
            bitIdx_d = '0;
            state_d  = (PARITY != 0) ? PAR : STOP;
          end else begin
            bitIdx_d = bitIdx_q + IW'(1);
          end
        end
      end
      PAR: begin
        if (cnt_q == LAST_CNT) begin
          if (rxS_q != parExp) parBad_d = 1'b1;
          state_d = STOP;
        end
      end
      // A low stop sample aborts at once; the last good one exits mid-bit.
      STOP: begin
        if (cnt_q == LAST_CNT) begin
          if (!rxS_q) begin
            frameBad_d = 1'b1;
            done_d     = 1'b1;
            state_d    = BREAK;
          end else if (stopIdx_q == LAST_STOP) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            stopIdx_d = 1'b1;
          end
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rxS_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // Completion cycle: frame errors discard the word, parity is advisory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      frameErr_q <= 1'b0;
      parErr_q   <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      frameErr_q <= 1'b0;
      parErr_q   <= 1'b0;
      overrun_q  <= 1'b0;
      if (tvalid_q && m_axis_tready) tvalid_q <= 1'b0;
      if (done_q) begin
        if (frameBad_q) begin
          frameErr_q <= 1'b1;
        end else begin
          parErr_q <= parBad_q;
          if (!tvalid_q || m_axis_tready) begin
            tdata_q  <= shift_q;
            tvalid_q <= 1'b1;
          end else begin
            overrun_q <= 1'b1;
          end
        end
      end
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign frame_error   = frameErr_q;
  assign parity_error  = parErr_q;
  assign overrun_error = overrun_q;

endmodule
